// File: rtl/seq_chunk_adder.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH bits processed CHUNK bits per clock.
// Optional signed-overflow output is built when SEQ_ADDER_OVERFLOW_EN is defined.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   // state | meaning
   // IDLE  | waiting for an operand pair, in_ready high
   // RUN   | adding one chunk per cycle, low chunk first
   // DONE  | result presented, waiting for out_ready
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             c_reg;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_res;
   logic             last;

   assign a_chunk   = a_reg[int'(idx)*CHUNK +: CHUNK];
   assign b_chunk   = b_reg[int'(idx)*CHUNK +: CHUNK];
   assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_reg};
   assign last      = (idx == IW'(NCH - 1));

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE);
   assign carry     = c_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         c_reg <= 1'b0;
         idx   <= '0;
         sum   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= in1;
                  b_reg <= sub ? ~in2 : in2;
                  c_reg <= sub | cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[int'(idx)*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
               c_reg <= chunk_res[CHUNK];
               idx   <= idx + 1'b1;
               if (last) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SEQ_ADDER_OVERFLOW_EN
   logic ov_reg;

   // The top result bit is produced by the last chunk, so it is taken from the adder directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         ov_reg <= 1'b0;
      end else if (state == RUN && last) begin
         ov_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                   (chunk_res[CHUNK-1] != a_reg[WIDTH-1]);
      end
   end

   assign overflow = ov_reg;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Multi-cycle, parametrised two's-complement adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock and carries between chunks through a registered carry. It replaces the fixed 32-bit combinational ripple chain in datapaths where the ALU is given several cycles. It provides a valid/ready handshake on both the operand side and the result side.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per cycle; NCH = WIDTH/CHUNK, with NCH >= 1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts operands this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A+~B+1 (A−B).
- out_valid  output  1  result held on sum/carry/overflow.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- carry  output  1  carry out of bit WIDTH−1; for sub, 1 means no borrow.
- overflow  output  1  signed overflow (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1 when reset = 0.
  - On in_valid & in_ready, latch in1, ~in2-or-in2 per sub, and the effective carry-in (cin, or 1 if sub). Clear the chunk index. Go to RUN.
- RUN:
  - Each cycle, add chunk k of A and B' plus the carry register with a CHUNK-bit ripple add.
  - Write result chunk k. Update the carry register. Increment k.
  - After chunk NCH−1, go to DONE.
- DONE:
  - out_valid = 1. sum, carry and overflow are stable.
  - On out_ready, go to IDLE.
- Arithmetic is modulo 2^WIDTH. carry is the true bit-WIDTH carry of the full-width add.
- Inputs are sampled only on the accepting edge. Changes to in1, in2, cin or sub afterwards have no effect.
- in_valid outside IDLE is ignored; no queueing.

## Timing
- Reset values: out_valid=0, sum=0, carry=0, overflow=0, state=IDLE, internal carry=0.
- in_ready is 0 while reset is asserted.
- Latency: the acceptance edge is cycle 0. Chunks are computed in cycles 1..NCH. out_valid rises in cycle NCH+1.
- out_valid stays high, and outputs hold, until the edge with out_ready=1.
- in_ready = 1 in the cycle after that handshake. Minimum initiation interval is NCH+2 cycles.
- No combinational path exists from in_* to out_*, or from out_ready to in_ready. in_ready is decoded from state (and reset) only.
- sum, carry and overflow are don't-care while not out_valid, except immediately after reset, when they are 0.
- Reset mid-operation (RUN or DONE) aborts the operation:
  - Outputs return to reset values on that edge.
  - in_ready = 1 in the first cycle with reset low.
  - The aborted result is never presented.
- NCH=1: RUN lasts one cycle; latency is 2.

## Configuration
- SEQ_ADDER_OVERFLOW_EN defined:
  - overflow is registered when entering DONE.
  - overflow = (A[WIDTH−1] == B'[WIDTH−1]) & (sum[WIDTH−1] != A[WIDTH−1]), where B' is the effective second operand.
- Macro undefined:
  - The overflow logic is not built; overflow is tied 0.
  - All other behaviour is identical.

## Test plan
- 1. WIDTH=32, CHUNK=8: accept in1=0xFFFFFFFF, in2=0x00000001, cin=0, sub=0 -> out_valid rises exactly 5 cycles after acceptance, with sum=0x00000000, carry=1, overflow=0.
- 2. Subtract: in1=5, in2=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, carry=0, overflow=0. Then in1=7, in2=5 -> sum=0x00000002, carry=1.
- 3. Overflow: in1=0x7FFFFFFF, in2=1, sub=0 -> sum=0x80000000, carry=0. overflow=1 with SEQ_ADDER_OVERFLOW_EN, 0 without.
- 4. Backpressure: hold out_ready=0 for 3 cycles in DONE and drive a second operand pair with in_valid=1 -> sum/carry stay constant, in_ready=0, the second pair is not accepted. After out_ready=1, in_ready=1 next cycle and the pair is accepted.
- 5. Reset in cycle 2 of RUN -> next edge: out_valid=0, sum=0, carry=0. in_ready=1 once reset is low. A subsequent 0x12345678+0x11111111 gives 0x23456789, carry=0.
- 6. WIDTH=8, CHUNK=8: in1=0xAA, in2=0x55, cin=1 -> out_valid 2 cycles after acceptance, sum=0x00, carry=1, overflow=0.
